// File: rtl/alu_operand_entry.sv
// Operand/op-code entry front end: steps A -> B -> OP -> SHOW on debounced button presses.
// Optional DEBOUNCE_EN inserts a DB_CYCLES stable-time filter in each button path.

module alu_operand_entry_btn #(
   parameter logic [19:0] DB_CYCLES = 20'd1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pulse
);
   logic s1, s2, lvl, prev, hold, arm;

   // hold blocks pulses after reset until the raw button has been seen low,
   // so a button held through reset never registers as a press
   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         prev  <= 1'b0;
         arm   <= 1'b0;
         hold  <= 1'b1;
         pulse <= 1'b0;
      end else begin
         s1    <= btn;
         s2    <= s1;
         prev  <= lvl;
         arm   <= 1'b1;
         if (arm && !s1) hold <= 1'b0;
         pulse <= lvl & ~prev & ~hold;
      end
   end

`ifdef DEBOUNCE_EN
   logic [19:0] cnt;
   logic        filt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         filt <= 1'b0;
      end else if (s2 != filt) begin
         if (cnt == DB_CYCLES - 20'd1) begin
            filt <= s2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 20'd1;
         end
      end else begin
         cnt <= '0;
      end
   end

   assign lvl = filt;
`else
   logic unused_db;
   assign unused_db = ^DB_CYCLES;
   assign lvl = s2;
`endif
endmodule

module alu_operand_entry #(
   parameter int          w         = 8,
   parameter logic [19:0] DB_CYCLES = 20'd1_000_000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [15:0]  sw,
   input  logic         btn_next,
   input  logic         btn_back,
   output logic [w-1:0] a,
   output logic [w-1:0] b,
   output logic [2:0]   op,
   output logic [1:0]   stage,
   output logic         valid,
   output logic         op_err
);
   typedef enum logic [1:0] {ENTER_A = 2'd0, ENTER_B = 2'd1, ENTER_OP = 2'd2, SHOW = 2'd3} state_t;

   state_t         state, state_n;
   logic [w-1:0]   a_n, b_n;
   logic [2:0]     op_n;
   logic           err_n;
   logic           nxt_p, bck_p, nxt_only, bck_only, op_legal;
   logic           unused_sw;

   assign unused_sw = ^sw;

   alu_operand_entry_btn #(.DB_CYCLES(DB_CYCLES)) u_next (
      .clk(clk), .reset(reset), .btn(btn_next), .pulse(nxt_p)
   );
   alu_operand_entry_btn #(.DB_CYCLES(DB_CYCLES)) u_back (
      .clk(clk), .reset(reset), .btn(btn_back), .pulse(bck_p)
   );

   assign nxt_only = nxt_p & ~bck_p;
   assign bck_only = bck_p & ~nxt_p;
   assign op_legal = (sw[2:0] == 3'b001) || (sw[2:0] == 3'b010) ||
                     (sw[2:0] == 3'b011) || (sw[2:0] == 3'b100);

   always_comb begin
      state_n = state;
      a_n     = a;
      b_n     = b;
      op_n    = op;
      err_n   = 1'b0;
      case (state)
         ENTER_A: begin
            if (nxt_only) begin
               a_n     = sw[w-1:0];
               state_n = ENTER_B;
            end
         end
         ENTER_B: begin
            if (nxt_only) begin
               b_n     = sw[w-1:0];
               state_n = ENTER_OP;
            end else if (bck_only) begin
               state_n = ENTER_A;
            end
         end
         ENTER_OP: begin
            if (nxt_only) begin
               state_n = SHOW;
               op_n    = op_legal ? sw[2:0] : 3'b001;
               err_n   = ~op_legal;
            end else if (bck_only) begin
               state_n = ENTER_B;
            end
         end
         SHOW: begin
            if (nxt_only)      state_n = ENTER_A;
            else if (bck_only) state_n = ENTER_OP;
         end
         default: state_n = ENTER_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ENTER_A;
         a      <= '0;
         b      <= '0;
         op     <= 3'b001;
         valid  <= 1'b0;
         op_err <= 1'b0;
      end else begin
         state  <= state_n;
         a      <= a_n;
         b      <= b_n;
         op     <= op_n;
         valid  <= (state_n == SHOW);
         op_err <= err_n;
      end
   end

   assign stage = state;
endmodule
